// File: rtl/serial_pkg.sv
// Shared definitions for the serial link transmitter and receiver: FSM states, line levels, parity.
// Pure declarations; no latency or backpressure of its own.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } serial_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam int   MAX_DATA_W  = 9;

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/baud_tick.sv
// Bit-time counter: one-cycle tick on the last cycle of every CLKS_PER_BIT window while enabled.
// Dropping enable clears the count, so each enabled period starts with a full bit time; no backpressure.
module baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = enable && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!enable || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_tx.sv
// UART-style transmitter: start bit, data LSB first, optional parity, stop bit(s); registered tx_out.
// Frame is (1+DATA_W+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles; tx_ready low for the whole frame, no queuing.
module serial_tx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_busy
);

  if (CLKS_PER_BIT < 2 || DATA_W < 5 || DATA_W > MAX_DATA_W ||
      (PARITY_EN != 0 && PARITY_EN != 1) || (PARITY_ODD != 0 && PARITY_ODD != 1) ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
    $error("serial_tx: illegal parameter combination");
  end

  localparam int BCNT_W = $clog2(DATA_W + 1);
  localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(DATA_W - 1);
  localparam logic [BCNT_W-1:0] LAST_STOP = BCNT_W'(STOP_BITS - 1);

  serial_state_t     state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic              parity_q, parity_d;
  logic              tx_out_q, tx_out_d;
  logic              ready_q;
  logic              bit_tick;

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(state_q != IDLE),
    .tick  (bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    case (state_q)
      IDLE: begin
        if (tx_valid && ready_q) begin
          shift_d   = tx_data;
          parity_d  = calc_parity(MAX_DATA_W'(tx_data), PARITY_ODD != 0);
          bit_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_tick) state_d = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_tick) state_d = STOP;
      end
      STOP: begin
        // bit_cnt is reused to count stop bits
        if (bit_tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the next state so the register lines up with the state change.
    tx_out_d = IDLE_LEVEL;
    case (state_d)
      START:   tx_out_d = START_LEVEL;
      DATA:    tx_out_d = shift_d[0];
      PARITY:  tx_out_d = parity_d;
      default: tx_out_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx_out_q  <= IDLE_LEVEL;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tx_out_q  <= tx_out_d;
      ready_q   <= (state_d == IDLE);
    end
  end

  assign tx_ready = ready_q;
  assign tx_out   = tx_out_q;
  assign tx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: four parameterisations, constant frame table, hand-written corner cases,
// then random words checked against a bit-list frame model.
module tb_serial_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data  [4];
  logic       tx_valid [4];
  logic       tx_ready [4];
  logic       tx_out   [4];
  logic       tx_busy  [4];

  int cpb_p [4] = '{4, 4, 4, 3};
  int pe_p  [4] = '{0, 1, 1, 0};
  int po_p  [4] = '{0, 0, 1, 0};
  int sb_p  [4] = '{1, 1, 1, 2};

  int tests = 0;
  int fails = 0;
  int hs_cnt [4] = '{default: 0};

  serial_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .tx_out(tx_out[0]), .tx_busy(tx_busy[0]));
  serial_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .tx_out(tx_out[1]), .tx_busy(tx_busy[1]));
  serial_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .tx_out(tx_out[2]), .tx_busy(tx_busy[2]));
  serial_tx #(.CLKS_PER_BIT(3), .DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_d3 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .tx_out(tx_out[3]), .tx_busy(tx_busy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (tx_valid[i] && tx_ready[i]) hs_cnt[i] = hs_cnt[i] + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] expand(input logic [15:0] bits, input int nb, input int cpb);
    logic [127:0] w = '0;
    int k = 0;
    for (int i = 0; i < nb; i++)
      for (int c = 0; c < cpb; c++) begin
        w[k] = bits[i];
        k++;
      end
    return w;
  endfunction

  // Reference: list the frame's bits, then stretch each one over a bit time.
  function automatic void model_frame(input logic [7:0] data, input int d,
                                      output logic [127:0] w, output int len);
    bit q[$];
    int k = 0;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(data[i]);
    if (pe_p[d] != 0) q.push_back((^data) ^ (po_p[d] != 0));
    for (int s = 0; s < sb_p[d]; s++) q.push_back(1'b1);
    w = '0;
    foreach (q[i])
      for (int c = 0; c < cpb_p[d]; c++) begin
        w[k] = q[i];
        k++;
      end
    len = k;
  endfunction

  task automatic wait_ready(input int d);
    int t = 0;
    @(negedge clk);
    while (!tx_ready[d] && t < 200) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("ready_before_send_d%0d", d), 128'(tx_ready[d]), 128'(1));
  endtask

  // Sends one word and records tx_out every cycle while busy; optionally pokes inputs mid-frame.
  task automatic run_frame(input int d, input logic [7:0] data, input int glitch_at,
                           output logic [127:0] wav, output int busy_n, output logic rdy_after);
    wait_ready(d);
    tx_data[d]  = data;
    tx_valid[d] = 1'b1;
    @(posedge clk);
    #1;
    tx_valid[d] = 1'b0;
    tx_data[d]  = 8'($urandom);
    wav    = '0;
    busy_n = 0;
    while (tx_busy[d] && busy_n < 120) begin
      wav[busy_n] = tx_out[d];
      if (busy_n == glitch_at) begin
        tx_data[d]  = 8'h3C;
        tx_valid[d] = 1'b1;
      end else begin
        tx_valid[d] = 1'b0;
      end
      busy_n++;
      @(posedge clk);
      #1;
    end
    tx_valid[d] = 1'b0;
    rdy_after   = tx_ready[d];
  endtask

  typedef struct {
    int          d;
    logic [7:0]  data;
    logic [15:0] bits;
    int          nb;
    int          len;
  } vec_t;

  initial begin
    vec_t         tbl[5];
    logic [127:0] wav, exp_w, w1;
    int           busy_n, len0, len1, h0, k;
    logic         rdy;
    logic [7:0]   data;
    int           d;

    tbl[0] = '{0, 8'hA5, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 40};
    tbl[1] = '{1, 8'hA5, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 44};
    tbl[2] = '{2, 8'hA5, {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, 44};
    tbl[3] = '{3, 8'hA5, {5'b0, 2'b11, 8'hA5, 1'b0}, 11, 33};
    tbl[4] = '{1, 8'h07, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 44};

    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tx_valid[i] = 1'b0;
      tx_data[i]  = 8'h00;
    end

    // Reset state
    #12;
    for (int i = 0; i < 4; i++)
      check($sformatf("reset_out_rdy_busy_d%0d", i), 128'({tx_out[i], tx_ready[i], tx_busy[i]}), 128'(3'b100));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_low_before_first_edge", 128'(tx_ready[0]), 128'(0));
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      check($sformatf("ready_after_first_edge_d%0d", i), 128'(tx_ready[i]), 128'(1));

    // Constant frame table
    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].d, tbl[i].data, -1, wav, busy_n, rdy);
      check($sformatf("tbl%0d_wave", i), wav, expand(tbl[i].bits, tbl[i].nb, cpb_p[tbl[i].d]));
      check($sformatf("tbl%0d_busy_cycles", i), 128'(busy_n), 128'(tbl[i].len));
      check($sformatf("tbl%0d_ready_after", i), 128'(rdy), 128'(1));
    end

    // Back-to-back 0x00 then 0xFF with tx_valid held
    wait_ready(0);
    h0 = hs_cnt[0];
    tx_data[0]  = 8'h00;
    tx_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    tx_data[0] = 8'hFF;
    wav = '0;
    for (k = 0; k < 81; k++) begin
      wav[k] = tx_out[0];
      if (k == 41) tx_valid[0] = 1'b0;
      @(posedge clk);
      #1;
    end
    tx_valid[0] = 1'b0;
    model_frame(8'h00, 0, exp_w, len0);
    model_frame(8'hFF, 0, w1, len1);
    exp_w[len0] = 1'b1;
    exp_w = exp_w | (w1 << (len0 + 1));
    check("b2b_wave", wav, exp_w);
    check("b2b_handshakes", 128'(hs_cnt[0] - h0), 128'(2));
    check("b2b_total_cycles", 128'(len0 + 1 + len1), 128'(81));

    // Input changes and a tx_valid pulse mid-frame are ignored
    h0 = hs_cnt[0];
    run_frame(0, 8'h81, 10, wav, busy_n, rdy);
    model_frame(8'h81, 0, exp_w, len0);
    check("stable_wave", wav, exp_w);
    check("stable_handshakes", 128'(hs_cnt[0] - h0), 128'(1));

    // Reset during DATA bit 3, off the clock edge
    wait_ready(0);
    tx_data[0]  = 8'hC3;
    tx_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    tx_valid[0] = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    check("midframe_busy_before_reset", 128'(tx_busy[0]), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("midframe_reset_out_rdy_busy", 128'({tx_out[0], tx_ready[0], tx_busy[0]}), 128'(3'b100));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_ready_low", 128'(tx_ready[0]), 128'(0));
    @(posedge clk);
    #1;
    check("post_reset_ready_out", 128'({tx_ready[0], tx_out[0], tx_busy[0]}), 128'(3'b110));
    h0 = hs_cnt[0];
    run_frame(0, 8'h5A, -1, wav, busy_n, rdy);
    model_frame(8'h5A, 0, exp_w, len0);
    check("post_reset_5a_wave", wav, exp_w);
    check("post_reset_5a_busy", 128'(busy_n), 128'(len0));
    check("post_reset_handshakes", 128'(hs_cnt[0] - h0), 128'(1));

    // Random words on random configurations
    for (int n = 0; n < 24; n++) begin
      d    = $urandom_range(0, 3);
      data = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_frame(d, data, -1, wav, busy_n, rdy);
      model_frame(data, d, exp_w, len0);
      check($sformatf("rand%0d_d%0d_%h_wave", n, d, data), wav, exp_w);
      check($sformatf("rand%0d_d%0d_busy", n, d), 128'(busy_n), 128'(len0));
      check($sformatf("rand%0d_d%0d_ready", n, d), 128'(rdy), 128'(1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
